vga_timing_gen: RTL and testbench

- Upstream raster timing source for the display pipeline.
- Divides the system clock down to a pixel rate and runs horizontal and vertical pixel counters for 640x480 at 60 Hz.
- Drives hpos, vpos and en into the background, sprite and compositor stages.
- Produces hsync/vsync delayed to line up with the registered colour output of those stages, plus frame and line strobes for game-state update logic.

---
 rtl/vga_timing_gen_pkg.sv | 25 ++
 rtl/vga_timing_gen_if.sv | 20 ++
 rtl/vga_timing_gen_sync_delay_line.sv | 25 ++
 rtl/vga_timing_gen.sv | 101 ++++++++++
 tb/tb_vga_timing_gen.sv | 219 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared display constants for the raster pipeline: 640x480@60 timing,
// position and colour widths, and a small window-decode helper.
package vga_timing_gen_pkg;
    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;
    localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    localparam int POS_W = 10;
    localparam int RGB_W = 8;

    typedef logic [POS_W-1:0] pos_t;
    typedef logic [RGB_W-1:0] rgb_t;

    // Half-open window test lo <= pos < hi, unsigned.
    function automatic logic in_window(input pos_t pos, input pos_t lo, input pos_t hi);
        return (pos >= lo) && (pos < hi);
    endfunction
endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the draw stages.
interface vga_timing_gen_if;
    import vga_timing_gen_pkg::*;

    pos_t hpos;
    pos_t vpos;
    logic en;
    logic pix_tick;
    logic hsync;
    logic vsync;
    logic line_start;
    logic frame_start;

    modport master (
        output hpos, vpos, en, pix_tick, hsync, vsync, line_start, frame_start
    );
    modport slave (
        input hpos, vpos, en, pix_tick, hsync, vsync, line_start, frame_start
    );
endinterface

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Fixed-depth register chain with a programmable reset value; used to align
// control signals with the registered colour path.
module vga_timing_gen_sync_delay_line #(
    parameter int                DATA_W  = 1,
    parameter int                STAGES  = 1,
    parameter logic [DATA_W-1:0] RST_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);
    logic [DATA_W-1:0] dly_p [STAGES];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) dly_p[i] <= RST_VAL;
        end else begin
            dly_p[0] <= din;
            for (int i = 1; i < STAGES; i++) dly_p[i] <= dly_p[i-1];
        end
    end

    assign dout = dly_p[STAGES-1];
endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing source: pixel-rate divider, h/v position counters, visible
// enable, latency-matched sync outputs and line/frame strobes.
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int H_ACTIVE   = VGA_H_ACTIVE,
    parameter int H_FP       = VGA_H_FP,
    parameter int H_SYNC     = VGA_H_SYNC,
    parameter int H_BP       = VGA_H_BP,
    parameter int V_ACTIVE   = VGA_V_ACTIVE,
    parameter int V_FP       = VGA_V_FP,
    parameter int V_SYNC     = VGA_V_SYNC,
    parameter int V_BP       = VGA_V_BP,
    parameter bit SYNC_POL   = 1'b0,
    parameter int SYNC_DELAY = 1
) (
    input logic              clk,
    input logic              rst,
    vga_timing_gen_if.master vga
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam pos_t H_LAST  = pos_t'(H_TOTAL - 1);
    localparam pos_t V_LAST  = pos_t'(V_TOTAL - 1);
    localparam pos_t H_VIS   = pos_t'(H_ACTIVE);
    localparam pos_t V_VIS   = pos_t'(V_ACTIVE);
    localparam pos_t HS_LO   = pos_t'(H_ACTIVE + H_FP);
    localparam pos_t HS_HI   = pos_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam pos_t VS_LO   = pos_t'(V_ACTIVE + V_FP);
    localparam pos_t VS_HI   = pos_t'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [1:0] SYNC_IDLE = {2{~SYNC_POL}};

    logic [DIV_W-1:0] div_cnt;
    logic             running;
    pos_t             hpos_r;
    pos_t             vpos_r;
    logic             line_start_r;
    logic             frame_start_r;
    logic             pix_tick;
    logic             h_wrap;
    logic             v_wrap;
    logic [1:0]       sync_lvl;
    logic [1:0]       sync_out;

    assign pix_tick = running && (div_cnt == DIV_LAST);
    assign h_wrap   = pix_tick && (hpos_r == H_LAST);
    assign v_wrap   = h_wrap && (vpos_r == V_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running       <= 1'b0;
            div_cnt       <= '0;
            hpos_r        <= '0;
            vpos_r        <= '0;
            line_start_r  <= 1'b0;
            frame_start_r <= 1'b0;
        end else begin
            running       <= 1'b1;
            line_start_r  <= h_wrap;
            frame_start_r <= v_wrap;
            if (running) begin
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
            end
            if (pix_tick) begin
                hpos_r <= h_wrap ? '0 : hpos_r + 1'b1;
                if (h_wrap) begin
                    vpos_r <= v_wrap ? '0 : vpos_r + 1'b1;
                end
            end
        end
    end

    // Sync is mapped to its output level before the delay line so every
    // stage resets straight to the idle level.
    assign sync_lvl = {in_window(hpos_r, HS_LO, HS_HI),
                       in_window(vpos_r, VS_LO, VS_HI)} ^ SYNC_IDLE;

    vga_timing_gen_sync_delay_line #(
        .DATA_W  (2),
        .STAGES  (SYNC_DELAY),
        .RST_VAL (SYNC_IDLE)
    ) u_sync_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (sync_lvl),
        .dout (sync_out)
    );

    assign vga.hpos        = hpos_r;
    assign vga.vpos        = vpos_r;
    assign vga.en          = running && (hpos_r < H_VIS) && (vpos_r < V_VIS);
    assign vga.pix_tick    = pix_tick;
    assign vga.hsync       = sync_out[1];
    assign vga.vsync       = sync_out[0];
    assign vga.line_start  = line_start_r;
    assign vga.frame_start = frame_start_r;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default timing, a tiny raster
// for frame-level behaviour, and a CLK_DIV=1 / delayed / active-high variant).
module tb_vga_timing_gen;
    import vga_timing_gen_pkg::*;

    // Small raster: 15 x 10 total, hsync window [10,13), vsync window [7,9).
    localparam int B_HA = 8, B_HFP = 2, B_HS = 3, B_HBP = 2;
    localparam int B_VA = 6, B_VFP = 1, B_VS = 2, B_VBP = 1;
    localparam int B_HT = B_HA + B_HFP + B_HS + B_HBP;
    localparam int B_VT = B_VA + B_VFP + B_VS + B_VBP;

    logic clk = 1'b0;
    logic rst_a, rst_b, rst_c;

    always #5 clk = ~clk;

    vga_timing_gen_if ifa ();
    vga_timing_gen_if ifb ();
    vga_timing_gen_if ifc ();

    vga_timing_gen u_dut_a (.clk(clk), .rst(rst_a), .vga(ifa));

    vga_timing_gen #(
        .CLK_DIV(2), .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
        .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
        .SYNC_POL(1'b0), .SYNC_DELAY(1)
    ) u_dut_b (.clk(clk), .rst(rst_b), .vga(ifb));

    vga_timing_gen #(
        .CLK_DIV(1), .SYNC_POL(1'b1), .SYNC_DELAY(3)
    ) u_dut_c (.clk(clk), .rst(rst_c), .vga(ifc));

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Pixel index reached after the n-th clk edge since reset release.
    function automatic int pix(input int n, input int d);
        return (n < 1) ? 0 : (n - 1) / d;
    endfunction

    // Expected {hpos, vpos, en, pix_tick, hsync, vsync, line_start, frame_start}
    // after the n-th edge since release (n = 0: in or just out of reset).
    function automatic logic [25:0] model(input int n, input int d, input int ht, input int vt,
                                          input int ha, input int va, input int hs_lo, input int hs_hi,
                                          input int vs_lo, input int vs_hi, input int sd, input bit pol);
        int p, h, v, m, pm, hm, vm;
        logic pt, en_e, ls, fs, hs, vs;
        p    = pix(n, d);
        h    = p % ht;
        v    = (p / ht) % vt;
        pt   = (n >= 1) && (((n - 1) % d) == d - 1);
        en_e = (n >= 1) && (h < ha) && (v < va);
        ls   = (n >= 2) && (p != pix(n - 1, d)) && (h == 0);
        fs   = ls && (v == 0);
        m    = n - sd;
        pm   = (m < 0) ? 0 : pix(m, d);
        hm   = pm % ht;
        vm   = (pm / ht) % vt;
        hs   = (m >= 0 && hm >= hs_lo && hm < hs_hi) ? pol : ~pol;
        vs   = (m >= 0 && vm >= vs_lo && vm < vs_hi) ? pol : ~pol;
        return {h[9:0], v[9:0], en_e, pt, hs, vs, ls, fs};
    endfunction

    function automatic logic [25:0] model_a(input int n);
        return model(n, 2, 800, 525, 640, 480, 656, 752, 490, 492, 1, 1'b0);
    endfunction
    function automatic logic [25:0] model_b(input int n);
        return model(n, 2, B_HT, B_VT, B_HA, B_VA, B_HA + B_HFP, B_HA + B_HFP + B_HS,
                     B_VA + B_VFP, B_VA + B_VFP + B_VS, 1, 1'b0);
    endfunction
    function automatic logic [25:0] model_c(input int n);
        return model(n, 1, 800, 525, 640, 480, 656, 752, 490, 492, 3, 1'b1);
    endfunction

    wire [25:0] vec_a = {ifa.hpos, ifa.vpos, ifa.en, ifa.pix_tick, ifa.hsync, ifa.vsync, ifa.line_start, ifa.frame_start};
    wire [25:0] vec_b = {ifb.hpos, ifb.vpos, ifb.en, ifb.pix_tick, ifb.hsync, ifb.vsync, ifb.line_start, ifb.frame_start};
    wire [25:0] vec_c = {ifc.hpos, ifc.vpos, ifc.en, ifc.pix_tick, ifc.hsync, ifc.vsync, ifc.line_start, ifc.frame_start};

    // Scoreboard: expectation pushed on each driving edge, popped mid-cycle.
    int n_a = 0, n_b = 0, n_c = 0;
    logic [25:0] q_a[$], q_b[$], q_c[$];

    always @(posedge clk) begin
        n_a <= rst_a ? 0 : n_a + 1;
        n_b <= rst_b ? 0 : n_b + 1;
        n_c <= rst_c ? 0 : n_c + 1;
        q_a.push_back(model_a(rst_a ? 0 : n_a + 1));
        q_b.push_back(model_b(rst_b ? 0 : n_b + 1));
        q_c.push_back(model_c(rst_c ? 0 : n_c + 1));
    end

    always @(negedge clk) begin
        if (q_a.size() > 0) chk("a_outputs", {6'b0, vec_a}, {6'b0, q_a.pop_front()});
        if (q_b.size() > 0) chk("b_outputs", {6'b0, vec_b}, {6'b0, q_b.pop_front()});
        if (q_c.size() > 0) chk("c_outputs", {6'b0, vec_c}, {6'b0, q_c.pop_front()});
    end

    // Interval and width measurements taken from the DUT outputs.
    int cyc = 0;
    int a_en_line0 = 0, a_ls_first = 0, a_ls_last = 0, a_ls_period = 0;
    int a_hs_low = 0, a_hs_width = 0, a_hs_fall_h = -1, a_hs_rise_h = -1;
    logic a_hs_prev = 1'b1;
    int c_pt_miss = 0, c_hs_high = 0, c_hs_width = 0, c_hs_rise_h = -1, c_hs_fall_h = -1;
    logic c_hs_prev = 1'b0;
    int b_fs_first = 0, b_fs_last = 0, b_fs_period = 0, b_fs_cnt = 0, b_fs_nols = 0;
    int b_ls_last = 0, b_ls_period = 0, b_en_bad = 0, b_vs_low = 0, b_vs_width = 0;
    logic b_vs_prev = 1'b1;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (ifa.en && ifa.vpos == 10'd0) a_en_line0 <= a_en_line0 + 1;
        if (ifa.line_start) begin
            if (a_ls_first == 0) a_ls_first <= n_a;
            else a_ls_period <= cyc - a_ls_last;
            a_ls_last <= cyc;
        end
        a_hs_low <= ifa.hsync ? 0 : a_hs_low + 1;
        if (a_hs_prev && !ifa.hsync && a_hs_fall_h < 0) a_hs_fall_h <= int'(ifa.hpos);
        if (!a_hs_prev && ifa.hsync && a_hs_width == 0) begin
            a_hs_width  <= a_hs_low;
            a_hs_rise_h <= int'(ifa.hpos);
        end
        a_hs_prev <= ifa.hsync;

        if (n_c >= 1 && !ifc.pix_tick) c_pt_miss <= c_pt_miss + 1;
        c_hs_high <= ifc.hsync ? c_hs_high + 1 : 0;
        if (!c_hs_prev && ifc.hsync && c_hs_rise_h < 0) c_hs_rise_h <= int'(ifc.hpos);
        if (c_hs_prev && !ifc.hsync && c_hs_width == 0) begin
            c_hs_width  <= c_hs_high;
            c_hs_fall_h <= int'(ifc.hpos);
        end
        c_hs_prev <= ifc.hsync;

        if (rst_b) begin
            b_fs_first <= 0;
            b_fs_cnt   <= 0;
        end else begin
            if (ifb.frame_start) begin
                if (b_fs_first == 0) b_fs_first <= n_b;
                else b_fs_period <= cyc - b_fs_last;
                b_fs_last <= cyc;
                b_fs_cnt  <= b_fs_cnt + 1;
                if (!ifb.line_start) b_fs_nols <= b_fs_nols + 1;
            end
            if (ifb.line_start) begin
                if (b_ls_last != 0) b_ls_period <= cyc - b_ls_last;
                b_ls_last <= cyc;
            end
            if (!b_vs_prev && ifb.vsync) b_vs_width <= b_vs_low;
        end
        if (ifb.en && ifb.vpos >= 10'(B_VA)) b_en_bad <= b_en_bad + 1;
        b_vs_low  <= ifb.vsync ? 0 : b_vs_low + 1;
        b_vs_prev <= ifb.vsync;
    end

    initial begin
        bit found;
        int fs_exp;
        rst_a = 1'b1;
        rst_b = 1'b1;
        rst_c = 1'b1;
        repeat (5) @(negedge clk);
        chk("a_rst_hsync", {31'b0, ifa.hsync}, 32'd1);
        chk("a_rst_vsync", {31'b0, ifa.vsync}, 32'd1);
        chk("c_rst_hsync", {31'b0, ifc.hsync}, 32'd0);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        rst_c = 1'b0;

        // Bring the small raster to a point inside both sync pulses.
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            @(negedge clk);
            #1;
            if (ifb.hpos == 10'd11 && ifb.vpos == 10'd7) found = 1'b1;
        end
        chk("b_reach_mid", {31'b0, found}, 32'd1);
        chk("b_mid_syncs", {30'b0, ifb.hsync, ifb.vsync}, 32'd0);
        rst_b = 1'b1;
        #1;
        chk("b_async_rst", {6'b0, vec_b}, {6'b0, model_b(0)});
        repeat (3) @(negedge clk);
        #1;
        rst_b = 1'b0;

        repeat (3300) @(negedge clk);
        #1;
        chk("a_en_line0", a_en_line0, 1280);
        chk("a_ls_first", a_ls_first, 1601);
        chk("a_ls_period", a_ls_period, 1600);
        chk("a_hs_fall_hpos", a_hs_fall_h, 656);
        chk("a_hs_rise_hpos", a_hs_rise_h, 752);
        chk("a_hs_width", a_hs_width, 192);
        chk("c_pix_tick_gap", c_pt_miss, 0);
        chk("c_hs_rise_hpos", c_hs_rise_h, 659);
        chk("c_hs_fall_hpos", c_hs_fall_h, 755);
        chk("c_hs_width", c_hs_width, 96);
        fs_exp = (n_b >= 301) ? (n_b - 301) / 300 + 1 : 0;
        chk("b_fs_first", b_fs_first, 301);
        chk("b_fs_period", b_fs_period, 300);
        chk("b_fs_count", b_fs_cnt, fs_exp);
        chk("b_fs_no_ls", b_fs_nols, 0);
        chk("b_ls_period", b_ls_period, 2 * B_HT);
        chk("b_vs_width", b_vs_width, 2 * B_HT * B_VS);
        chk("b_en_blank", b_en_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
